// File: rtl/osc_pkg.sv
// Shared definitions for the oscillator control slice: mode width, the
// number of valid modes, the Q3.29 coefficient ROM and the FSM encoding.
// ROM rows: mode k uses w = pi / 2^(6-k), amplitude A = 1.0.
package osc_pkg;

    localparam int MODE_W    = 4;
    localparam int NUM_MODES = 5;
    localparam int COEF_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } osc_state_e;

    // A*sin(w), Q3.29
    localparam logic [COEF_W-1:0] COEF_SIN [NUM_MODES] = '{
        32'd26343006,    // w = pi/64
        32'd52622551,    // w = pi/32
        32'd104738320,   // w = pi/16
        32'd205451598,   // w = pi/8
        32'd379625062    // w = pi/4
    };

    // 2cos(w), Q3.29
    localparam logic [COEF_W-1:0] COEF_2COS [NUM_MODES] = '{
        32'd1072448455,
        32'd1068571461,
        32'd1053110174,
        32'd992008094,
        32'd759250125
    };

    // ROM lookups; codes outside the table fall back to row 0.
    function automatic logic [COEF_W-1:0] coef_sin(input logic [MODE_W-1:0] m);
        logic [COEF_W-1:0] r;
        r = COEF_SIN[0];
        for (int i = 0; i < NUM_MODES; i++) begin
            if (m == MODE_W'(i)) r = COEF_SIN[i];
        end
        return r;
    endfunction

    function automatic logic [COEF_W-1:0] coef_2cos(input logic [MODE_W-1:0] m);
        logic [COEF_W-1:0] r;
        r = COEF_2COS[0];
        for (int i = 0; i < NUM_MODES; i++) begin
            if (m == MODE_W'(i)) r = COEF_2COS[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/osc_rate_div.sv
// Sample-rate divider: counts 0..ratio-1 while run is high and raises tick
// for one cycle after each wrap. clear forces the count and tick to zero.
// ratio must be non-zero (the parent latches 0 as 1).
module osc_rate_div #(
    parameter int DIV_W = 16
) (
    input  logic             Fg_CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] ratio,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Free-running modulo-ratio counter; tick is registered off the wrap.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            if (cnt >= ratio - DIV_W'(1)) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + DIV_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/oscillator_ctrl.sv
// Control stage ahead of the recursive sine/cosine oscillator: IDLE/LOAD/RUN
// sequencing, coefficient ROM selection, Ready load pulse, Enable sample
// strobe (via osc_rate_div) and freqchange retune requests.
// Optional feature macro: OSC_AUTO_SWEEP_EN (automatic mode sweep in RUN,
// one step every SWEEP_TICKS Enable strobes).
//
// Handshake: Ready and freqchange are single-cycle pulses with no back
// pressure; the oscillator must take init1/init2/Mode in the cycle the
// pulse is high. Enable is a one-cycle strobe per sample period.
module oscillator_ctrl
    import osc_pkg::*;
#(
`ifdef OSC_AUTO_SWEEP_EN
    parameter int SWEEP_TICKS = 4096,
`endif
    parameter int DIV_W = 16
) (
    input  logic              Fg_CLK,
    input  logic              RESET,
    input  logic              Start,
    input  logic              Stop,
    input  logic              ModeWr,
    input  logic [MODE_W-1:0] ModeSel,
    input  logic [DIV_W-1:0]  DivRatio,
    output logic              Enable,
    output logic              Ready,
    output logic [COEF_W-1:0] init1,
    output logic [COEF_W-1:0] init2,
    output logic [MODE_W-1:0] Mode,
    output logic              freqchange,
    output logic              Busy,
    output logic              ModeErr,
    output osc_state_e        dbg_state
);

    osc_state_e        state_q, state_d;
    logic [DIV_W-1:0]  ratio_q;
    logic              start_acc, mode_valid, user_wr, user_load, err_set;
    logic              div_run, div_clear;
    logic [MODE_W-1:0] mode_d;
    logic              fc_d;

    // Stop outranks Start and ModeWr everywhere below.
    assign start_acc  = (state_q == IDLE) && Start && !Stop;
    assign mode_valid = (ModeSel < MODE_W'(NUM_MODES));
    assign user_wr    = ModeWr && !Stop && mode_valid;
    assign user_load  = user_wr && ((state_q != RUN) || (ModeSel != Mode));
    assign err_set    = ModeWr && !Stop && !mode_valid;
    assign div_run    = (state_q == RUN) && !Stop;
    assign div_clear  = !div_run;
    assign dbg_state  = state_q;

    // Next-state logic for the IDLE -> LOAD -> RUN sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_acc) state_d = LOAD;
            LOAD:    state_d = Stop ? IDLE : RUN;
            RUN:     if (Stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus Ready/Busy decoded from the next state so they
    // line up with the state they describe; ratio latched on accepted Start.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            Ready   <= 1'b0;
            Busy    <= 1'b0;
            ratio_q <= DIV_W'(1);
        end else begin
            state_q <= state_d;
            Ready   <= (state_d == LOAD);
            Busy    <= (state_d != IDLE);
            if (start_acc) ratio_q <= (DivRatio == '0) ? DIV_W'(1) : DivRatio;
        end
    end

    osc_rate_div #(.DIV_W(DIV_W)) u_rate_div (
        .Fg_CLK (Fg_CLK),
        .RESET  (RESET),
        .clear  (div_clear),
        .run    (div_run),
        .ratio  (ratio_q),
        .tick   (Enable)
    );

`ifdef OSC_AUTO_SWEEP_EN
    logic [31:0] sweep_cnt;
    logic        sweep_step;

    // A user retune in the same cycle takes precedence over a sweep step.
    assign sweep_step = div_run && Enable && !user_load &&
                        (sweep_cnt == 32'(SWEEP_TICKS - 1));

    // Counts Enable strobes in RUN; restarts on a user retune or a step.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            sweep_cnt <= '0;
        end else if (!div_run || user_load) begin
            sweep_cnt <= '0;
        end else if (Enable) begin
            sweep_cnt <= sweep_step ? 32'd0 : sweep_cnt + 32'd1;
        end
    end
`endif

    // Mode selection: user writes first, then (optionally) the sweep.
    always_comb begin
        mode_d = Mode;
        fc_d   = 1'b0;
        if (user_load) begin
            mode_d = ModeSel;
            fc_d   = (state_q == RUN);
        end
`ifdef OSC_AUTO_SWEEP_EN
        else if (sweep_step) begin
            mode_d = (Mode == MODE_W'(NUM_MODES - 1)) ? '0 : Mode + MODE_W'(1);
            fc_d   = 1'b1;
        end
`endif
    end

    // Mode and coefficient registers move together; freqchange marks a retune.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            Mode       <= '0;
            init1      <= COEF_SIN[0];
            init2      <= COEF_2COS[0];
            freqchange <= 1'b0;
        end else begin
            Mode       <= mode_d;
            init1      <= coef_sin(mode_d);
            init2      <= coef_2cos(mode_d);
            freqchange <= fc_d;
        end
    end

    // Sticky invalid-mode flag, cleared only by an accepted Start.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            ModeErr <= 1'b0;
        end else if (err_set) begin
            ModeErr <= 1'b1;
        end else if (start_acc) begin
            ModeErr <= 1'b0;
        end
    end

endmodule
